// File: rtl/hs_sync_pkg.sv
// Shared types and parameter defaults for the hs_sync_ctrl CDC receive controller.
package hs_sync_pkg;

    localparam int unsigned NUM_STAGES_DEF     = 2;
    localparam int unsigned BUS_WIDTH_DEF      = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACK_WAIT = 2'b01,
        DRAIN    = 2'b10
    } state_t;

endpackage

// File: rtl/hs_sync_ctrl_if.sv
// Four-phase REQ/ACK crossing bundle: master is the source side, slave is the receive controller.
interface hs_sync_ctrl_if
    import hs_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF
);
    logic                 async_req;
    logic [BUS_WIDTH-1:0] async_data;
    logic                 ack;
    logic [BUS_WIDTH-1:0] sync_data;
    logic                 sync_valid;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output async_req, async_data,
        input  ack, sync_data, sync_valid, busy, timeout_err
    );

    modport slave (
        input  async_req, async_data,
        output ack, sync_data, sync_valid, busy, timeout_err
    );
endinterface

// File: rtl/hs_sync_ctrl_bit_sync.sv
// Multi-flop synchroniser for signals arriving asynchronously to clk.
module bit_sync
    import hs_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 1,
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] d_i,
    output logic [BUS_WIDTH-1:0] q_o
);
    logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[NUM_STAGES-1];
endmodule

// File: rtl/hs_sync_ctrl.sv
// Destination-side controller for a 4-phase REQ/ACK multi-bit crossing.
// Optional ACK timeout with DRAIN state is compiled in by defining HS_SYNC_TIMEOUT_EN.
module hs_sync_ctrl
    import hs_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = NUM_STAGES_DEF,
    parameter int unsigned BUS_WIDTH      = BUS_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    hs_sync_ctrl_if.slave  hs
);
    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
            $error("hs_sync_ctrl: NUM_STAGES must be 2..4");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("hs_sync_ctrl: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    logic req_s;

    bit_sync #(
        .BUS_WIDTH  (1),
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (hs.async_req),
        .q_o   (req_s)
    );

    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;

`ifdef HS_SYNC_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    // Next state and registered outputs; data only moves on the IDLE -> ACK_WAIT edge
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef HS_SYNC_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_s) begin
                    data_d  = hs.async_data;
                    valid_d = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK_WAIT;
`ifdef HS_SYNC_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ACK_WAIT: begin
                ack_d = 1'b1;
`ifdef HS_SYNC_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // A falling request wins over a coincident terminal count
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
`ifdef HS_SYNC_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    ack_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = DRAIN;
                end
`endif
            end
`ifdef HS_SYNC_TIMEOUT_EN
            DRAIN: begin
                ack_d = 1'b0;
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef HS_SYNC_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef HS_SYNC_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign hs.ack        = ack_q;
    assign hs.sync_data  = data_q;
    assign hs.sync_valid = valid_q;
    assign hs.busy       = busy_q;
`ifdef HS_SYNC_TIMEOUT_EN
    assign hs.timeout_err = terr_q;
`else
    assign hs.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_hs_sync_ctrl.sv
// Self-checking bench for hs_sync_ctrl: scoreboarded captures plus cycle-level handshake timing.
module tb_hs_sync_ctrl;
    import hs_sync_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned BW = 8;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hs_sync_ctrl_if #(.BUS_WIDTH(BW)) hs ();

    hs_sync_ctrl #(
        .NUM_STAGES     (NS),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hs    (hs.slave)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int n_valid  = 0;
    int n_pushed = 0;
    int n_terr   = 0;
    int exp_terr = 0;
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] sb_exp;

    // Scoreboard: every SYNC_VALID pulse must match the oldest outstanding transfer
    always @(negedge clk) begin
        if (hs.timeout_err === 1'b1) n_terr++;
        if (hs.sync_valid === 1'b1) begin
            n_valid++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra_valid: got valid with data %h, expected no capture", hs.sync_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (hs.sync_data !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_data: got %h expected %h", hs.sync_data, sb_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [BW-1:0] d);
        exp_q.push_back(d);
        n_pushed++;
    endtask

    task automatic test_reset();
        hs.async_req  = 1'b1;
        hs.async_data = 8'hA5;
        tick(3);
        n_cmp++;
        if ({hs.ack, hs.sync_valid, hs.busy, hs.timeout_err, hs.sync_data} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b valid=%b busy=%b terr=%b data=%h expected all zero",
                     hs.ack, hs.sync_valid, hs.busy, hs.timeout_err, hs.sync_data);
        end
        push_exp(8'hA5);
        rst_n = 1'b1;
        tick(2);
        n_cmp++;
        if (hs.ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_early_ack: got %b expected 0", hs.ack);
        end
        tick(1);
        n_cmp++;
        if ({hs.ack, hs.sync_data} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL reset_release_capture: got ack=%b data=%h expected ack=1 data=a5", hs.ack, hs.sync_data);
        end
        hs.async_req = 1'b0;
        tick(3);
        n_cmp++;
        if ({hs.ack, hs.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release_rtz: got ack=%b busy=%b expected 0 0", hs.ack, hs.busy);
        end
        tick(1);
    endtask

    task automatic test_single();
        hs.async_data = 8'h3C;
        hs.async_req  = 1'b1;
        push_exp(8'h3C);
        tick(2);
        n_cmp++;
        if (hs.ack !== 1'b0) begin
            n_err++;
            $display("FAIL single_ack_early: got %b expected 0", hs.ack);
        end
        tick(1);
        n_cmp++;
        if ({hs.ack, hs.sync_valid, hs.busy} !== 3'b111) begin
            n_err++;
            $display("FAIL single_capture: got ack=%b valid=%b busy=%b expected 1 1 1", hs.ack, hs.sync_valid, hs.busy);
        end
        tick(1);
        n_cmp++;
        if ({hs.ack, hs.sync_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL single_valid_pulse: got ack=%b valid=%b expected 1 0", hs.ack, hs.sync_valid);
        end
        tick(1);
        hs.async_req = 1'b0;
        tick(2);
        n_cmp++;
        if (hs.ack !== 1'b1) begin
            n_err++;
            $display("FAIL single_ack_hold: got %b expected 1", hs.ack);
        end
        tick(1);
        n_cmp++;
        if ({hs.ack, hs.busy, hs.sync_data} !== {2'b00, 8'h3C}) begin
            n_err++;
            $display("FAIL single_rtz: got ack=%b busy=%b data=%h expected 0 0 3c", hs.ack, hs.busy, hs.sync_data);
        end
        tick(1);
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] words [2];
        int            v0;
        words[0] = 8'h11;
        words[1] = 8'h22;
        v0 = n_valid;
        for (int i = 0; i < 2; i++) begin
            hs.async_data = words[i];
            hs.async_req  = 1'b1;
            push_exp(words[i]);
            tick(3);
            n_cmp++;
            if ({hs.ack, hs.sync_data} !== {1'b1, words[i]}) begin
                n_err++;
                $display("FAIL b2b_capture[%0d]: got ack=%b data=%h expected ack=1 data=%h", i, hs.ack, hs.sync_data, words[i]);
            end
            tick(1);
            hs.async_req = 1'b0;
            tick(3);
            n_cmp++;
            if (hs.ack !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_rtz[%0d]: got ack=%b expected 0", i, hs.ack);
            end
            tick(1);
        end
        n_cmp++;
        if (n_valid - v0 !== 2) begin
            n_err++;
            $display("FAIL b2b_valid_count: got %0d pulses expected 2", n_valid - v0);
        end
    endtask

    task automatic test_data_change();
        hs.async_data = 8'h5A;
        hs.async_req  = 1'b1;
        push_exp(8'h5A);
        tick(3);
        hs.async_data = 8'hFF;
        tick(3);
        n_cmp++;
        if ({hs.ack, hs.sync_data} !== {1'b1, 8'h5A}) begin
            n_err++;
            $display("FAIL datachg_hold: got ack=%b data=%h expected ack=1 data=5a", hs.ack, hs.sync_data);
        end
        hs.async_req = 1'b0;
        tick(3);
        n_cmp++;
        if ({hs.ack, hs.sync_data} !== {1'b0, 8'h5A}) begin
            n_err++;
            $display("FAIL datachg_rtz: got ack=%b data=%h expected ack=0 data=5a", hs.ack, hs.sync_data);
        end
        tick(1);
    endtask

`ifdef HS_SYNC_TIMEOUT_EN
    task automatic test_timeout_tie();
        hs.async_data = 8'h77;
        hs.async_req  = 1'b1;
        push_exp(8'h77);
        tick(3);
        tick(5);
        hs.async_req = 1'b0;
        tick(2);
        n_cmp++;
        if (hs.ack !== 1'b1) begin
            n_err++;
            $display("FAIL tie_ack_hold: got %b expected 1", hs.ack);
        end
        tick(1);
        n_cmp++;
        if ({hs.ack, hs.timeout_err, hs.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL tie_normal_completion: got ack=%b terr=%b busy=%b expected 0 0 0", hs.ack, hs.timeout_err, hs.busy);
        end
        tick(1);
    endtask

    task automatic test_timeout();
        hs.async_data = 8'hE1;
        hs.async_req  = 1'b1;
        push_exp(8'hE1);
        tick(3);
        tick(TO - 1);
        n_cmp++;
        if ({hs.ack, hs.timeout_err} !== 2'b10) begin
            n_err++;
            $display("FAIL timeout_early: got ack=%b terr=%b expected 1 0", hs.ack, hs.timeout_err);
        end
        tick(1);
        exp_terr++;
        n_cmp++;
        if ({hs.ack, hs.timeout_err, hs.busy} !== 3'b011) begin
            n_err++;
            $display("FAIL timeout_fire: got ack=%b terr=%b busy=%b expected 0 1 1", hs.ack, hs.timeout_err, hs.busy);
        end
        tick(5);
        n_cmp++;
        if ({hs.ack, hs.timeout_err, hs.busy, hs.sync_data} !== {3'b001, 8'hE1}) begin
            n_err++;
            $display("FAIL timeout_drain: got ack=%b terr=%b busy=%b data=%h expected 0 0 1 e1",
                     hs.ack, hs.timeout_err, hs.busy, hs.sync_data);
        end
        hs.async_req = 1'b0;
        tick(2);
        n_cmp++;
        if (hs.busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_drain_exit_early: got busy=%b expected 1", hs.busy);
        end
        tick(1);
        n_cmp++;
        if (hs.busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_drain_exit: got busy=%b expected 0", hs.busy);
        end
        tick(1);
    endtask
`endif

    task automatic test_reset_mid();
        hs.async_data = 8'h96;
        hs.async_req  = 1'b1;
        push_exp(8'h96);
        tick(4);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({hs.ack, hs.busy, hs.sync_valid, hs.sync_data} !== 11'h000) begin
            n_err++;
            $display("FAIL midreset_async: got ack=%b busy=%b valid=%b data=%h expected all zero",
                     hs.ack, hs.busy, hs.sync_valid, hs.sync_data);
        end
        tick(2);
        rst_n = 1'b1;
        push_exp(8'h96);
        tick(2);
        n_cmp++;
        if (hs.ack !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_early_ack: got %b expected 0", hs.ack);
        end
        tick(1);
        n_cmp++;
        if ({hs.ack, hs.sync_data} !== {1'b1, 8'h96}) begin
            n_err++;
            $display("FAIL midreset_recapture: got ack=%b data=%h expected ack=1 data=96", hs.ack, hs.sync_data);
        end
        hs.async_req = 1'b0;
        tick(3);
        n_cmp++;
        if (hs.ack !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_rtz: got ack=%b expected 0", hs.ack);
        end
        tick(2);
    endtask

    task automatic test_end();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL end_missing_captures: %0d transfers never produced SYNC_VALID", exp_q.size());
        end
        n_cmp++;
        if (n_valid != n_pushed) begin
            n_err++;
            $display("FAIL end_valid_count: got %0d pulses expected %0d", n_valid, n_pushed);
        end
        n_cmp++;
        if (n_terr != exp_terr) begin
            n_err++;
            $display("FAIL end_timeout_pulses: got %0d expected %0d", n_terr, exp_terr);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        hs.async_req  = 1'b0;
        hs.async_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_data_change();
`ifdef HS_SYNC_TIMEOUT_EN
        test_timeout_tie();
        test_timeout();
`endif
        test_reset_mid();
        test_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hs_sync_ctrl.md
# hs_sync_ctrl

Destination-domain controller for a 4-phase REQ/ACK clock-domain-crossing handshake carrying a BUS_WIDTH-bit data word. It synchronises the incoming request through a multi-flop bit synchroniser, captures the quasi-static bus, and pulses a valid flag. It drives ACK back to the source domain and sequences the return-to-zero phase. It sits at the receive side of every multi-bit crossing in the design, in front of the consuming logic.

## Interface
- NUM_STAGES, 2, synchroniser depth on ASYNC_REQ (legal range 2 to 4)
- BUS_WIDTH, 8, width of the transferred data word
- TIMEOUT_CYCLES, 64, cycles ACK may wait for REQ to fall (used only with the timeout feature)

- CLK  in  1  destination-domain clock, rising edge
- RST  in  1  asynchronous, active-low reset
- ASYNC_REQ  in  1  request from source domain, asynchronous to CLK
- ASYNC_DATA  in  BUS_WIDTH  source data; source holds it stable from REQ rise until it sees ACK high
- ACK  out  1  acknowledge to source domain, registered
- SYNC_DATA  out  BUS_WIDTH  captured word, registered, holds until the next capture
- SYNC_VALID  out  1  one-cycle pulse marking a new SYNC_DATA
- BUSY  out  1  high whenever the state is not IDLE
- TIMEOUT_ERR  out  1  one-cycle pulse on handshake timeout

## Operation
- req_s is ASYNC_REQ after NUM_STAGES flops, all cleared by RST.
- FSM states: IDLE, ACK_WAIT, DRAIN. DRAIN exists only with the timeout feature.
- IDLE, req_s=1: capture SYNC_DATA<=ASYNC_DATA, SYNC_VALID<=1, ACK<=1, go to ACK_WAIT.
- IDLE, req_s=0: hold. ACK=0.
- ACK_WAIT: SYNC_VALID<=0. ACK stays 1.
- ACK_WAIT, req_s=0: ACK<=0, go to IDLE.
- ACK_WAIT, timeout (feature on): ACK<=0, TIMEOUT_ERR<=1 for one cycle, go to DRAIN. SYNC_DATA is kept.
- DRAIN: ACK=0. Go to IDLE when req_s=0. No capture happens in DRAIN, so a stuck REQ is never recaptured.
- Capture happens only on an IDLE-to-ACK_WAIT transition, exactly once per REQ high phase.
- Because leaving ACK_WAIT requires req_s=0, consecutive transfers always include a full return-to-zero phase.
- Reset values: ACK=0, SYNC_DATA=0, SYNC_VALID=0, BUSY=0, TIMEOUT_ERR=0, state IDLE, synchroniser flops 0, timeout counter 0.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous). If ASYNC_REQ is still high after RST deasserts, the FSM treats it as a new request after NUM_STAGES cycles.

## Timing
- Edge numbering: ASYNC_REQ is stable high before edge 1.
- req_s goes high after edge NUM_STAGES.
- ACK, SYNC_VALID and new SYNC_DATA are visible after edge NUM_STAGES+1. For NUM_STAGES=2 that is 3 edges.
- SYNC_VALID is high for exactly one cycle.
- Return to zero: ASYNC_REQ low before edge m gives ACK low after edge m+NUM_STAGES.
- Minimum back-to-back period as seen at CLK: 2*(NUM_STAGES+1) cycles plus source-side synchroniser latency.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Clears on entry to ACK_WAIT and increments every cycle in ACK_WAIT.
  - Timeout fires on the edge where the count equals TIMEOUT_CYCLES-1 and req_s is still 1.
  - If req_s=0 and the terminal count occur on the same edge, req_s=0 wins: normal completion, no error.

## Configuration
- HS_SYNC_TIMEOUT_EN defined:
  - Timeout counter, DRAIN state and TIMEOUT_ERR logic are compiled in.
  - TIMEOUT_CYCLES is active.
- HS_SYNC_TIMEOUT_EN undefined:
  - No counter and no DRAIN state.
  - ACK_WAIT waits for req_s=0 indefinitely.
  - TIMEOUT_ERR is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package hs_sync_pkg holds:
  - the state typedef (IDLE=2'b00, ACK_WAIT=2'b01, DRAIN=2'b10);
  - localparam defaults for NUM_STAGES and TIMEOUT_CYCLES.
- One sub-module: the existing multi-flop synchroniser BIT_SYNC, instantiated with BUS_WIDTH=1 and NUM_STAGES passed through, with CLK and RST shared.
- The FSM, capture register and timeout counter live in hs_sync_ctrl.

## Test plan
- Reset: hold RST=0 while ASYNC_REQ=1 and ASYNC_DATA=8'hA5 -> all outputs 0 and BUSY=0. After release, ACK=1 and SYNC_DATA=8'hA5 appear at the 3rd edge.
- Single transfer (NUM_STAGES=2): ASYNC_DATA=8'h3C, then REQ rise -> SYNC_VALID pulses for 1 cycle at edge 3 with SYNC_DATA=8'h3C. ACK stays high until 3 edges after REQ falls.
- Back-to-back: transfer 8'h11 then 8'h22, with REQ rising 1 cycle after ACK falls -> exactly two SYNC_VALID pulses. SYNC_DATA shows 8'h11 then 8'h22, with no duplicate capture.
- Data change after capture: change ASYNC_DATA to 8'hFF while in ACK_WAIT -> SYNC_DATA keeps the captured value and no extra SYNC_VALID occurs.
- Timeout (macro on, TIMEOUT_CYCLES=8): hold REQ high -> ACK falls and TIMEOUT_ERR pulses once 8 cycles after ACK rose. The FSM stays in DRAIN, with no recapture, until REQ falls, then returns to IDLE.
- Reset mid-handshake: assert RST while in ACK_WAIT -> ACK, BUSY and SYNC_VALID go to 0 immediately, without waiting for a clock edge.
